// File: rtl/icache_if.sv
// icache_if: fetch request/response channel between the IF stage and the instruction cache.
interface icache_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  modport master (output req, addr, input ready, rdata);
  modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, instruction-cache fetch handshake and IF/ID pipeline register.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  icache_if.master    ic,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o
);
  typedef enum logic [1:0] {REQ, DROP, HOLD} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, redir_q, redir_d, hold_instr_q, hold_instr_d, hold_pc_q, hold_pc_d;
  logic [31:0] instr_q, instr_d, pco_q, pco_d, rpc;
  logic valid_q, valid_d, started_q, rdy, acc;
  assign rpc = {redirect_pc_i[31:2], 2'b00};
  assign ic.req = started_q && state_q != HOLD;
  assign ic.addr = pc_q;
  assign rdy = ic.req && ic.ready;
  assign acc = !stall_i || !valid_q;
  assign instr_o = instr_q;
  assign pc_o = pco_q;
  assign pc_plus4_o = pco_q + 32'd4;
  assign instr_valid_o = valid_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    redir_d = redir_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d = hold_pc_q;
    pco_d = pco_q;
    instr_d = (acc || redirect_i) ? NOP_INSTR : instr_q;
    valid_d = (acc || redirect_i) ? 1'b0 : valid_q;
    if (state_q == REQ) begin
      if (rdy && redirect_i) pc_d = rpc;
      else if (rdy) begin
        pc_d = pc_q + 32'd4;
        if (acc) begin
          instr_d = ic.rdata;
          pco_d = pc_q;
          valid_d = 1'b1;
        end else begin
          hold_instr_d = ic.rdata;
          hold_pc_d = pc_q;
          state_d = HOLD;
        end
      end else if (redirect_i && started_q) begin
        redir_d = rpc;
        state_d = DROP;
      end else if (redirect_i) pc_d = rpc;
    end else if (state_q == DROP) begin
      // The outstanding stale request must complete before the target can be fetched.
      if (redirect_i) redir_d = rpc;
      if (rdy) begin
        pc_d = redirect_i ? rpc : redir_q;
        state_d = REQ;
      end
    end else begin
      if (redirect_i) begin
        pc_d = rpc;
        state_d = REQ;
      end else if (!stall_i) begin
        instr_d = hold_instr_q;
        pco_d = hold_pc_q;
        valid_d = 1'b1;
        state_d = REQ;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q <= RESET_PC;
      redir_q <= '0;
      hold_instr_q <= '0;
      hold_pc_q <= '0;
      instr_q <= NOP_INSTR;
      pco_q <= '0;
      valid_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      redir_q <= redir_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q <= hold_pc_d;
      instr_q <= instr_d;
      pco_q <= pco_d;
      valid_q <= valid_d;
      started_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed scenarios plus randomized run against a stream-level fetch model.
module tb_instr_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst_n, stall, redirect;
  logic [31:0] rpc, instr, pco, pc4;
  logic valid;
  int n_chk = 0, n_fail = 0;
  icache_if ic ();
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign ic.rdata = mem(ic.addr);
  instr_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .ic(ic), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(rpc), .instr_o(instr), .pc_o(pco), .pc_plus4_o(pc4), .instr_valid_o(valid)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_instr"}, instr, NOP);
    check({tag, "_pc"}, pco, 32'h0);
    check({tag, "_pc4"}, pc4, 32'h4);
    check({tag, "_valid"}, {31'b0, valid}, 32'h0);
    check({tag, "_req"}, {31'b0, ic.req}, 32'h0);
  endtask
  logic p_valid, p_stall, p_redir, p_req, p_ready;
  logic [31:0] p_instr, p_pc, p_addr, exp_pc;
  int idle;
  initial begin
    rst_n = 1'b0; ic.ready = 1'b1; stall = 1'b0; redirect = 1'b0; rpc = '0;
    @(negedge clk); @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    step;
    check("t1_req", {31'b0, ic.req}, 32'h1);
    check("t1_valid0", {31'b0, valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step;
      check("t1_pc", pco, 32'(i * 4));
      check("t1_instr", instr, mem(32'(i * 4)));
      check("t1_valid", {31'b0, valid}, 32'h1);
    end
    ic.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      check("t2_addr", ic.addr, 32'hC);
      check("t2_valid", {31'b0, valid}, 32'h0);
    end
    ic.ready = 1'b1;
    step;
    check("t2_pc", pco, 32'hC);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("t3_hold_pc", pco, 32'hC);
      check("t3_req", {31'b0, ic.req}, 32'h0);
    end
    stall = 1'b0;
    step;
    check("t3_pc_a", pco, 32'h10);
    step;
    check("t3_pc_b", pco, 32'h14);
    ic.ready = 1'b0;
    step;
    check("t4_addr", ic.addr, 32'h18);
    redirect = 1'b1; rpc = 32'h100;
    step;
    redirect = 1'b0;
    check("t4_drop_addr", ic.addr, 32'h18);
    check("t4_drop_req", {31'b0, ic.req}, 32'h1);
    step;
    check("t4_drop_valid", {31'b0, valid}, 32'h0);
    ic.ready = 1'b1;
    step;
    check("t4_new_addr", ic.addr, 32'h100);
    check("t4_no_stale", {31'b0, valid}, 32'h0);
    step;
    check("t4_pc", pco, 32'h100);
    check("t4_instr", instr, mem(32'h100));
    stall = 1'b1; redirect = 1'b1; rpc = 32'h203;
    step;
    check("t5_valid", {31'b0, valid}, 32'h0);
    check("t5_instr", instr, NOP);
    check("t5_addr", ic.addr, 32'h200);
    stall = 1'b0; redirect = 1'b0;
    step;
    check("t5_pc", pco, 32'h200);
    redirect = 1'b1; rpc = 32'hFFFF_FFFC;
    step;
    redirect = 1'b0;
    check("t6_addr", ic.addr, 32'hFFFF_FFFC);
    step;
    check("t6_pc", pco, 32'hFFFF_FFFC);
    check("t6_pc4", pc4, 32'h0);
    check("t6_wrap_addr", ic.addr, 32'h0);
    step;
    check("t6_pc0", pco, 32'h0);
    ic.ready = 1'b0;
    step;
    check("t7_req", {31'b0, ic.req}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    rst_n = 1'b1;
    p_valid = 0; p_stall = 0; p_redir = 0; p_req = 0; p_ready = 0;
    p_instr = NOP; p_pc = 0; p_addr = 0; exp_pc = 0; idle = 0;
    for (int i = 0; i < 3000; i++) begin
      ic.ready = $urandom_range(0, 9) < 7;
      stall = $urandom_range(0, 9) < 3;
      redirect = $urandom_range(0, 31) == 0;
      rpc = $urandom;
      if (redirect) exp_pc = {rpc[31:2], 2'b00};
      p_valid = valid; p_stall = stall; p_redir = redirect; p_req = ic.req;
      p_ready = ic.ready; p_instr = instr; p_pc = pco; p_addr = ic.addr;
      step;
      if (p_req && !p_ready) check("r_addr_stable", ic.addr, p_addr);
      check("r_align", {30'b0, ic.addr[1:0]}, 32'h0);
      check("r_pc4", pc4, pco + 32'd4);
      if (p_redir) begin
        check("r_flush_valid", {31'b0, valid}, 32'h0);
        check("r_flush_instr", instr, NOP);
      end else if (p_stall && p_valid) begin
        check("r_stall_valid", {31'b0, valid}, 32'h1);
        check("r_stall_instr", instr, p_instr);
        check("r_stall_pc", pco, p_pc);
      end else if (valid) begin
        check("r_seq_pc", pco, exp_pc);
        exp_pc = pco + 32'd4;
      end
      if (valid) check("r_instr", instr, mem(pco));
      else check("r_nop", instr, NOP);
      idle = valid ? 0 : idle + 1;
      if (idle > 64) begin
        check("r_watchdog", 32'(idle), 32'h0);
        break;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
